// File: rtl/rr_mux_pkg.sv
// Shared types and defaults for the round-robin slot mux.
// Holds the FSM state type and a width helper.
package rr_mux_pkg;

   typedef enum logic {IDLE, GRANT} state_t;

   localparam int NREQ_DEF = 4;
   localparam int DW_DEF   = 4;
   localparam int CW_DEF   = 4;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority search: first set req after ptr, modulo NREQ.
// ptr itself is checked last, so a lone requester still wins.
module rr_pick
   import rr_mux_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int SW   = clog2(NREQ_DEF)
) (
   input  logic [NREQ-1:0] req,
   input  logic [SW-1:0]   ptr,
   output logic [SW-1:0]   win,
   output logic            any
);

   logic [SW-1:0] j;

   // Walk from farthest to nearest so the nearest hit wins.
   always_comb begin
      win = '0;
      any = 1'b0;
      j   = '0;
      for (int k = NREQ; k >= 1; k--) begin
         j = SW'((int'(ptr) + k) % NREQ);
         if (req[j]) begin
            win = j;
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_slot_mux_ctrl.sv
// Round-robin time-slot scheduler driving a shared DW-bit mux output.
// Each grant owns the output for max(slot_len,1) cycles, then one gap cycle.
module rr_slot_mux_ctrl
   import rr_mux_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int DW   = DW_DEF,
   parameter int SW   = clog2(NREQ),
   parameter int CW   = CW_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [CW-1:0]    slot_len,
   input  logic [NREQ-1:0]  req,
   input  logic [NREQ*DW-1:0] din,
   output logic [NREQ-1:0]  grant,
   output logic [SW-1:0]    sel,
   output logic [DW-1:0]    dout,
   output logic             dout_valid,
   output logic [CW-1:0]    slot_cnt,
   output logic             busy
);

   state_t        state;
   logic [CW-1:0] len_q;
   logic [SW-1:0] ptr;
   logic [SW-1:0] win;
   logic          any;
   logic [DW-1:0] din_win;
   logic [DW-1:0] din_sel;
   logic          last;

   rr_pick #(
      .NREQ (NREQ),
      .SW   (SW)
   ) u_pick (
      .req (req),
      .ptr (ptr),
      .win (win),
      .any (any)
   );

   assign din_win = din[int'(win)*DW +: DW];
   assign din_sel = din[int'(sel)*DW +: DW];

   // Early release when the owner drops its request.
   assign last = (slot_cnt == len_q - CW'(1)) || !req[sel];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         grant      <= '0;
         sel        <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
         slot_cnt   <= '0;
         busy       <= 1'b0;
         ptr        <= SW'(NREQ-1);
         len_q      <= CW'(1);
      end else begin
         unique case (state)
            IDLE: begin
               if (en && any) begin
                  state      <= GRANT;
                  grant      <= NREQ'(1) << win;
                  sel        <= win;
                  dout       <= din_win;
                  dout_valid <= 1'b1;
                  busy       <= 1'b1;
                  slot_cnt   <= '0;
                  len_q      <= (slot_len == '0) ? CW'(1) : slot_len;
               end
            end
            GRANT: begin
               if (last) begin
                  state      <= IDLE;
                  grant      <= '0;
                  dout_valid <= 1'b0;
                  busy       <= 1'b0;
                  slot_cnt   <= '0;
                  ptr        <= sel;
               end else begin
                  dout     <= din_sel;
                  slot_cnt <= slot_cnt + CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rr_slot_mux_ctrl.sv
// Scoreboard bench for rr_slot_mux_ctrl: reference model pushes
// expected owner/data per cycle, a negedge monitor pops and compares.
module tb_rr_slot_mux_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic [3:0]  slot_len = '0;
   logic [3:0]  req = '0;
   logic [15:0] din = '0;
   logic [3:0]  grant;
   logic [1:0]  sel;
   logic [3:0]  dout;
   logic        dout_valid;
   logic [3:0]  slot_cnt;
   logic        busy;

   rr_slot_mux_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .slot_len   (slot_len),
      .req        (req),
      .din        (din),
      .grant      (grant),
      .sel        (sel),
      .dout       (dout),
      .dout_valid (dout_valid),
      .slot_cnt   (slot_cnt),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      int         own;
      logic [3:0] dat;
      int         cnt;
   } exp_t;

   exp_t q[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;
   bit   run = 1'b0;

   int         m_own = -1;
   int         m_ptr = 3;
   int         m_len = 1;
   int         m_cnt = 0;
   logic [3:0] m_dat = '0;

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, got, want);
      end
   endtask

   // Owner-based model: who holds the output and how many cycles remain.
   task automatic model_edge();
      int  j;
      bit  found;
      if (m_own < 0) begin
         if (en && req != 4'd0) begin
            found = 1'b0;
            for (int k = 1; k <= 4; k++) begin
               j = (m_ptr + k) % 4;
               if (!found && req[j]) begin
                  m_own = j;
                  found = 1'b1;
               end
            end
            m_len = (slot_len == 4'd0) ? 1 : int'(slot_len);
            m_cnt = 0;
            m_dat = din[m_own*4 +: 4];
         end
      end else if (m_cnt == m_len - 1 || !req[m_own]) begin
         m_ptr = m_own;
         m_own = -1;
         m_cnt = 0;
      end else begin
         m_cnt++;
         m_dat = din[m_own*4 +: 4];
      end
      if (m_own >= 0)
         q.push_back('{cyc: cyc, own: m_own, dat: m_dat, cnt: m_cnt});
   endtask

   task automatic step(input logic e, input logic [3:0] s,
                       input logic [3:0] r, input logic [15:0] d);
      en       = e;
      slot_len = s;
      req      = r;
      din      = d;
      @(posedge clk);
      cyc++;
      model_edge();
      #1;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_grant"}, 32'(grant), 32'd0);
      chk({tag, "_sel"}, 32'(sel), 32'd0);
      chk({tag, "_dout"}, 32'(dout), 32'd0);
      chk({tag, "_valid"}, 32'(dout_valid), 32'd0);
      chk({tag, "_cnt"}, 32'(slot_cnt), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   // Called at posedge+1; asserts reset between edges.
   task automatic pulse_reset();
      #2 rst_n = 1'b0;
      q.delete();
      m_own = -1;
      m_ptr = 3;
      m_cnt = 0;
      #1 check_zero("midreset");
      @(negedge clk);
      #1 rst_n = 1'b1;
   endtask

   always @(negedge clk) begin
      if (rst_n && run) begin
         while (q.size() > 0 && q[0].cyc < cyc) begin
            n_chk++;
            n_fail++;
            $display("FAIL missing_valid cyc=%0d got=0 want=1", q[0].cyc);
            void'(q.pop_front());
         end
         if (dout_valid) begin
            if (q.size() == 0 || q[0].cyc != cyc) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_valid cyc=%0d got=1 want=0", cyc);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("grant", 32'(grant), 32'(4'b0001 << e.own));
               chk("sel", 32'(sel), 32'(e.own));
               chk("dout", 32'(dout), 32'(e.dat));
               chk("slot_cnt", 32'(slot_cnt), 32'(e.cnt));
               chk("busy", 32'(busy), 32'd1);
            end
         end else begin
            if (q.size() > 0 && q[0].cyc == cyc) begin
               n_chk++;
               n_fail++;
               $display("FAIL missing_valid cyc=%0d got=0 want=1", cyc);
               void'(q.pop_front());
            end
            chk("idle_grant", 32'(grant), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_cnt", 32'(slot_cnt), 32'd0);
         end
      end
   end

   initial begin
      logic [3:0] rr;
      #12 check_zero("reset");
      rst_n = 1'b1;
      run   = 1'b1;

      for (int i = 0; i < 10; i++)
         step(1, 4'd3, 4'b0001, {12'($urandom), 4'hA});
      for (int i = 0; i < 16; i++)
         step(1, 4'd2, 4'b1111, 16'($urandom));
      for (int i = 0; i < 8; i++)
         step(1, 4'd0, 4'b0101, 16'($urandom));
      for (int i = 0; i < 5; i++)
         step(1, 4'd8, 4'b1100, 16'($urandom));
      for (int i = 0; i < 10; i++)
         step(1, 4'd8, 4'b1000, 16'($urandom));
      for (int i = 0; i < 2; i++)
         step(1, 4'd5, 4'b1111, 16'($urandom));
      for (int i = 0; i < 12; i++)
         step(0, 4'd5, 4'b1111, 16'($urandom));
      for (int i = 0; i < 6; i++)
         step(1, 4'd5, 4'b1111, 16'($urandom));
      for (int i = 0; i < 20; i++)
         step(1, 4'd15, 4'b0010, 16'($urandom));

      for (int i = 0; i < 2; i++)
         step(0, 4'd6, 4'b1111, 16'($urandom));
      for (int i = 0; i < 3; i++)
         step(1, 4'd6, 4'b1111, 16'($urandom));
      pulse_reset();
      for (int i = 0; i < 6; i++)
         step(1, 4'd4, 4'b1000, 16'($urandom));

      rr = 4'($urandom);
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(3) == 0) rr = 4'($urandom);
         step($urandom_range(7) != 0, 4'($urandom), rr,
              16'($urandom));
      end
      for (int i = 0; i < 20; i++)
         step(1, 4'd0, 4'b0000, 16'($urandom));

      @(negedge clk);
      #1 chk("queue_empty", 32'(q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
